// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings, control constants and widths for the HI/LO divider.
package div_unit_pkg;
  localparam int OpWidth = 32;
  localparam int DoubleRegBus = 64;
  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_t;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic RstEnable = 1'b1;
  localparam logic [OpWidth-1:0] ZeroWord = '0;
  function automatic logic [OpWidth-1:0] mag(input logic [OpWidth-1:0] v);
    return v[OpWidth-1] ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 step on the {partial remainder, quotient} working register.
module div_step
  import div_unit_pkg::*;
(
  input  logic [64:0]        work,
  input  logic [OpWidth-1:0] divisor,
  output logic [64:0]        work_next
);
  logic [64:0] sh;
  logic [33:0] diff;
  always_comb begin
    sh = work << 1;
    diff = {1'b0, sh[64:32]} - {2'b0, divisor};
    work_next = diff[33] ? sh : {diff[32:0], sh[31:1], 1'b1};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit DIV/DIVU sequencer producing {remainder, quotient} for HI/LO.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor through the BYZERO state.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    annul_i,
  input  logic                    signed_div_i,
  input  logic [OpWidth-1:0]      opdata1_i,
  input  logic [OpWidth-1:0]      opdata2_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic                    busy_o
);
  div_state_t state;
  logic [4:0] cnt;
  logic [64:0] work, work_next;
  logic [OpWidth-1:0] dvsr, q_fix, r_fix;
  logic neg_q, neg_r;
  logic go;
  div_step u_step (.work(work), .divisor(dvsr), .work_next(work_next));
  always_comb begin
    go = start_i == DivStart && !annul_i;
    q_fix = neg_q ? -work_next[31:0] : work_next[31:0];
    r_fix = neg_r ? -work_next[63:32] : work_next[63:32];
    busy_o = state == DivOn || state == DivByZero || (state == DivFree && go);
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= DivFree;
      result_o <= '0;
      ready_o <= DivResultNotReady;
      cnt <= '0;
      work <= '0;
      dvsr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DivFree: if (go) begin
`ifdef DIV_ZERO_FAST_EN
          state <= opdata2_i == ZeroWord ? DivByZero : DivOn;
`else
          state <= DivOn;
`endif
          cnt <= '0;
          work <= {33'b0, signed_div_i ? mag(opdata1_i) : opdata1_i};
          dvsr <= signed_div_i ? mag(opdata2_i) : opdata2_i;
          neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_r <= signed_div_i & opdata1_i[31];
        end
        DivByZero: begin
          state <= annul_i ? DivFree : DivEnd;
          ready_o <= annul_i ? DivResultNotReady : DivResultReady;
          result_o <= '0;
        end
        DivOn: if (annul_i) state <= DivFree;
        else begin
          work <= work_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DivEnd;
            ready_o <= DivResultReady;
            result_o <= {r_fix, q_fix};
          end
        end
        DivEnd: if (annul_i || start_i == DivStop) begin
          state <= DivFree;
          ready_o <= DivResultNotReady;
          result_o <= '0;
        end
        default: state <= DivFree;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit; zero-divisor expectations follow DIV_ZERO_FAST_EN.
module tb_div_unit;
  logic clk = 0, rst = 1, start = 0, annul = 0, sgn = 0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [63:0] result;
  logic ready, busy;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  div_unit dut (.clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
                .opdata1_i(op1), .opdata2_i(op2), .result_o(result), .ready_o(ready), .busy_o(busy));
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [63:0] res, output logic busy_bad);
    @(negedge clk);
    op1 = a; op2 = b; sgn = s; start = 1; annul = 0; busy_bad = 0; lat = 0;
    #1 if (!busy) busy_bad = 1;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin op1 = 32'hDEADBEEF; op2 = '0; end
      if (ready) break;
      if (!busy) busy_bad = 1;
    end
    res = result;
    if (busy) busy_bad = 1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst = 0;
  endtask
  task automatic test_divu;
    int lat; logic [63:0] res; logic bb;
    do_div(32'd100, 32'd7, 0, lat, res, bb);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got %h want %h", res, {32'd2, 32'd14}); end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL divu_busy: got bad=%b want 0", bb); end
    @(negedge clk); start = 0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL divu_drop_ready: got %b want 0", ready); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL divu_drop_result: got %h want 0", result); end
  endtask
  task automatic test_signed;
    logic [31:0] a [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] b [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
    logic        s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] e [4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                           {32'd0, 32'h80000000}, {32'd0, 32'hFFFFFFFF}};
    for (int i = 0; i < 4; i++) begin
      int lat; logic [63:0] res; logic bb;
      do_div(a[i], b[i], s[i], lat, res, bb);
      checks++; if (res !== e[i]) begin errors++; $display("FAIL signed_%0d_result: got %h want %h", i, res, e[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL signed_%0d_latency: got %0d want 33", i, lat); end
      @(negedge clk); start = 0;
    end
  endtask
  task automatic test_div_zero;
    int lat; logic [63:0] res; logic bb;
    do_div(32'd5, 32'd0, 0, lat, res, bb);
`ifdef DIV_ZERO_FAST_EN
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL zero_result: got %h want 0", res); end
`else
    checks++; if (lat !== 33) begin errors++; $display("FAIL zero_latency: got %0d want 33", lat); end
    checks++; if (res !== {32'd5, 32'hFFFFFFFF}) begin errors++; $display("FAIL zero_result: got %h want %h", res, {32'd5, 32'hFFFFFFFF}); end
`endif
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL zero_busy: got bad=%b want 0", bb); end
    @(negedge clk); start = 0;
  endtask
  task automatic test_annul;
    int lat; logic [63:0] res; logic bb;
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; sgn = 0; start = 1;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL annul_pre: got busy=%b ready=%b want 1 0", busy, ready); end
    @(negedge clk); annul = 1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_idle_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b0 || result !== 64'd0) begin errors++; $display("FAIL annul_outputs: got ready=%b result=%h want 0 0", ready, result); end
    do_div(32'd9, 32'd3, 0, lat, res, bb);
    checks++; if (lat !== 33) begin errors++; $display("FAIL annul_restart_latency: got %0d want 33", lat); end
    checks++; if (res !== {32'd0, 32'd3}) begin errors++; $display("FAIL annul_restart_result: got %h want %h", res, {32'd0, 32'd3}); end
    @(negedge clk); start = 0;
  endtask
  task automatic test_back_to_back;
    int lat; logic [63:0] res; logic bb;
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; sgn = 0; start = 1;
    repeat (21) @(posedge clk);
    @(negedge clk); rst = 1; start = 0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0 || result !== 64'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got ready=%b result=%h busy=%b want 0 0 0", ready, result, busy); end
    @(negedge clk); rst = 0;
    do_div(32'd100, 32'd7, 0, lat, res, bb);
    checks++; if (res !== {32'd2, 32'd14} || lat !== 33) begin
      errors++; $display("FAIL rst_recover: got %h lat %0d want %h lat 33", res, lat, {32'd2, 32'd14}); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || result !== res) begin
        errors++; $display("FAIL hold_%0d: got ready=%b result=%h want 1 %h", i, ready, result, res); end
    end
    @(negedge clk); start = 0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_drop_ready: got %b want 0", ready); end
    do_div(32'd9, 32'd3, 0, lat, res, bb);
    checks++; if (res !== {32'd0, 32'd3} || lat !== 33) begin
      errors++; $display("FAIL back_to_back: got %h lat %0d want %h lat 33", res, lat, {32'd0, 32'd3}); end
    @(negedge clk); start = 0;
  endtask
  initial begin
    test_reset;
    test_divu;
    test_signed;
    test_div_zero;
    test_annul;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider and sequencer for the HI/LO register pair, serving the DIV and DIVU instructions. It sits beside the execute stage and accepts a start request with two operands. It runs a restoring radix-2 division, one quotient bit per cycle. It holds busy so the pipeline stalls, then presents {remainder, quotient} with a ready flag so execute can write HI (remainder) and LO (quotient) through the HI/LO write port.

## Interface
- No parameters. Operand width is fixed at 32 and result width at 64 via shared defines.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a division; held high by execute until ready_o is seen.
- annul_i  in  1  cancel the operation in flight (flush or exception).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  32  dividend; sampled only on the start edge.
- opdata2_i  in  32  divisor; sampled only on the start edge.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o = 1.
- ready_o  out  1  result valid.
- busy_o  out  1  stall request to pipeline control.

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 with divisor ≠ 0 → ON. Latch |dividend| and |divisor| (magnitudes only when signed_div_i=1). Latch sign flags. Clear the 5-bit step counter and the 65-bit working register.
  - start_i=1 and annul_i=0 with divisor = 0 → BYZERO.
- BYZERO: next edge → END with result_o = 0.
- ON: each edge:
  - Shift the working register left 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the difference is non-negative, keep it and set quotient bit = 1; otherwise keep the shifted value and set the bit to 0.
  - Counter +1.
  - After step 31, the edge goes to END, registers result_o with the sign fixup, and sets ready_o.
- Sign fixup (signed only):
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder is negated when the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no trap).
- END: ready_o=1 and result_o stable while start_i=1. When start_i=0 → IDLE next edge, with ready_o=0 and result_o=0.
- annul_i=1 in BYZERO, ON or END → IDLE next edge; ready_o=0, result_o=0. annul_i has priority over start_i and over completion.
- busy_o = 1 in BYZERO and ON, and in IDLE when start_i=1 and annul_i=0 (combinational, so the start cycle stalls). busy_o = 0 in END.
- rst=1 in any state → IDLE; result_o=0, ready_o=0, counter=0, working register=0; busy_o is then 0 unless start_i=1.

## Timing
- Latency, start edge to ready_o: 33 cycles (1 start edge + 32 steps; the END entry is on the 32nd step edge). Divide-by-zero latency is 2 cycles.
- ready_o and result_o are registered. busy_o is the only combinational output.
- Operand changes after the start edge have no effect.
- A new start needs at least one IDLE cycle after END, so back-to-back initiation interval ≥ 34 cycles.
- result_o is never partially updated: only the END-entry edge writes it.

## Configuration
- DIV_ZERO_FAST_EN defined: a zero divisor takes the BYZERO path, giving 2-cycle latency and result_o = 0.
- DIV_ZERO_FAST_EN undefined:
  - The BYZERO state is not built. A zero divisor runs the full 32 steps.
  - Unsigned result: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed: the same magnitudes, then the normal sign fixup.

## Structure
- Shared defines file:
  - State encodings DivFree, DivByZero, DivOn, DivEnd.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - ZeroWord, RstEnable, DoubleRegBus width.
- Sub-module div_step: combinational single restoring step.
  - Input: 65-bit working register and 32-bit divisor.
  - Output: next working register.
  - Instantiated once in div_unit.

## Test plan
- DIVU 100 / 7 → ready_o rises 33 cycles after the start edge; result_o = {32'd2, 32'd14}; busy_o high throughout, low in END.
- DIV -7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / -2 → quotient 0xFFFFFFFD, remainder 0x1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide 5 by 0:
  - Macro on: ready_o after 2 cycles, result 0.
  - Macro off: ready_o after 33 cycles, {32'd5, 32'hFFFFFFFF}.
- Start 100/7, assert annul_i at step 10 → IDLE next edge. ready_o never rises. An immediate new start of 9/3 → {0, 3} after 33 cycles.
- Assert rst at step 20 → all outputs 0 next edge. Hold start_i high in END for 5 cycles → result stable; drop start_i → ready_o=0 next edge.
